// File: rtl/gru_gate_mac_unit_pkg.sv
// ============================================================================
// Module  : gru_pkg
// Brief   : Shared types and fixed-point helpers for the GRU gate MAC unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package gru_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      MAC_X = 3'd1,
      MAC_H = 3'd2,
      BIAS  = 3'd3,
      ACT   = 3'd4,
      OUT   = 3'd5
   } state_t;

   typedef enum logic {
      ACT_SIGMOID = 1'b0,
      ACT_TANH    = 1'b1
   } act_sel_e;

   // Helpers work on a 64-bit signed carrier; callers size-cast in and out.
   localparam int c_CALC_W = 64;

   function automatic logic signed [c_CALC_W-1:0] saturate(
      input logic signed [c_CALC_W-1:0] v,
      input int                         width
   );
      logic signed [c_CALC_W-1:0] hi;
      logic signed [c_CALC_W-1:0] lo;
      logic signed [c_CALC_W-1:0] res;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      if (v > hi)      res = hi;
      else if (v < lo) res = lo;
      else             res = v;
      return res;
   endfunction

   function automatic logic signed [c_CALC_W-1:0] sigmoid_approx(
      input logic signed [c_CALC_W-1:0] x,
      input int                         frac_bits
   );
      logic signed [c_CALC_W-1:0] one;
      logic signed [c_CALC_W-1:0] half;
      logic signed [c_CALC_W-1:0] lim;
      logic signed [c_CALC_W-1:0] res;
      one  = 64'sd1 <<< frac_bits;
      half = one >>> 1;
      lim  = half * 64'sd5;
      if (x < -lim)     res = '0;
      else if (x > lim) res = one;
      else              res = (x >>> 2) + (x >>> 3) + half;
      return res;
   endfunction

   function automatic logic signed [c_CALC_W-1:0] tanh_hard(
      input logic signed [c_CALC_W-1:0] x,
      input int                         frac_bits
   );
      logic signed [c_CALC_W-1:0] one;
      logic signed [c_CALC_W-1:0] res;
      one = 64'sd1 <<< frac_bits;
      if (x > one)       res = one;
      else if (x < -one) res = -one;
      else               res = x;
      return res;
   endfunction

endpackage

`default_nettype wire

// File: rtl/gru_gate_mac_unit_mac_lanes.sv
// ============================================================================
// Module  : gru_mac_lanes
// Brief   : Combinational LANES-wide signed product-sum, widened to ACC_WIDTH.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gru_mac_lanes #(
   parameter int DATA_WIDTH = 16,
   parameter int LANES      = 4,
   parameter int ACC_WIDTH  = 41
) (
   input  logic [LANES*DATA_WIDTH-1:0] i_op_a,
   input  logic [LANES*DATA_WIDTH-1:0] i_op_b,
   output logic [ACC_WIDTH-1:0]        o_sum
);

   localparam int c_PROD_W = 2 * DATA_WIDTH;

   logic signed [c_PROD_W-1:0] w_prod [LANES];

   generate
      for (genvar g = 0; g < LANES; g++) begin : g_lane
         logic signed [c_PROD_W-1:0] w_a_ext;
         logic signed [c_PROD_W-1:0] w_b_ext;
         // Widen before multiplying so the full-precision product is kept.
         assign w_a_ext   = c_PROD_W'($signed(i_op_a[g*DATA_WIDTH +: DATA_WIDTH]));
         assign w_b_ext   = c_PROD_W'($signed(i_op_b[g*DATA_WIDTH +: DATA_WIDTH]));
         assign w_prod[g] = w_a_ext * w_b_ext;
      end
   endgenerate

   always_comb begin
      o_sum = '0;
      for (int l = 0; l < LANES; l++) begin
         o_sum = o_sum + ACC_WIDTH'(w_prod[l]);
      end
   end

endmodule

`default_nettype wire

// File: rtl/gru_gate_mac_unit.sv
// ============================================================================
// Module  : gru_gate_mac_unit
// Brief   : One GRU gate neuron, y = act(Wx.x + Wh.h + bx + bh), LANES MACs
//           per cycle. GRU_GATE_SAT_FLAG_EN adds the sat_flag output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gru_gate_mac_unit
   import gru_pkg::*;
#(
   parameter int D          = 128,
   parameter int H          = 256,
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 8,
   parameter int LANES      = 4,
   parameter int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(D + H)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    act_sel,
   input  logic [D*DATA_WIDTH-1:0] x_t,
   input  logic [H*DATA_WIDTH-1:0] h_t_prev,
   input  logic [D*DATA_WIDTH-1:0] W_x_row,
   input  logic [H*DATA_WIDTH-1:0] W_h_row,
   input  logic [DATA_WIDTH-1:0]   b_x,
   input  logic [DATA_WIDTH-1:0]   b_h,
   output logic [DATA_WIDTH-1:0]   y,
   output logic                    out_valid,
   input  logic                    out_ready
`ifdef GRU_GATE_SAT_FLAG_EN
   ,
   output logic                    sat_flag
`endif
);

   localparam int c_IDX_W = $clog2(((D > H) ? D : H) + 1);
   localparam int c_GRP_W = LANES * DATA_WIDTH;

   generate
      if ((D % LANES) != 0 || (H % LANES) != 0) begin : g_cfg_check
         $error("gru_gate_mac_unit: D and H must be multiples of LANES");
      end
   endgenerate

   state_t                       r_state;
   state_t                       w_state_nxt;
   logic [c_IDX_W-1:0]           r_idx;
   logic signed [ACC_WIDTH-1:0]  r_acc;
   act_sel_e                     r_act_sel;
   logic signed [DATA_WIDTH-1:0] r_pre_sat;
   logic signed [DATA_WIDTH-1:0] r_y;
   logic                         r_out_valid;

   logic [c_GRP_W-1:0]           w_op_a;
   logic [c_GRP_W-1:0]           w_op_b;
   logic [ACC_WIDTH-1:0]         w_grp_sum;
   logic signed [ACC_WIDTH-1:0]  w_pre;
   logic signed [DATA_WIDTH-1:0] w_pre_sat;
   logic                         w_last_x;
   logic                         w_last_h;

   assign w_last_x = (r_idx == c_IDX_W'(D - LANES));
   assign w_last_h = (r_idx == c_IDX_W'(H - LANES));

   // Lane l sees element idx+l: shift the flat vector down and keep one group.
   always_comb begin
      w_op_a = c_GRP_W'(x_t     >> (32'(r_idx) * DATA_WIDTH));
      w_op_b = c_GRP_W'(W_x_row >> (32'(r_idx) * DATA_WIDTH));
      if (r_state == MAC_H) begin
         w_op_a = c_GRP_W'(h_t_prev >> (32'(r_idx) * DATA_WIDTH));
         w_op_b = c_GRP_W'(W_h_row  >> (32'(r_idx) * DATA_WIDTH));
      end
   end

   gru_mac_lanes #(
      .DATA_WIDTH (DATA_WIDTH),
      .LANES      (LANES),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_mac_lanes (
      .i_op_a (w_op_a),
      .i_op_b (w_op_b),
      .o_sum  (w_grp_sum)
   );

   assign w_pre     = (r_acc >>> FRAC_BITS)
                    + ACC_WIDTH'($signed(b_x))
                    + ACC_WIDTH'($signed(b_h));
   assign w_pre_sat = DATA_WIDTH'(saturate(64'(w_pre), DATA_WIDTH));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = MAC_X;
         end
         MAC_X:   if (w_last_x) w_state_nxt = MAC_H;
         MAC_H:   if (w_last_h) w_state_nxt = BIAS;
         BIAS:    w_state_nxt = ACT;
         ACT:     w_state_nxt = OUT;
         OUT:     if (out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx       <= '0;
         r_acc       <= '0;
         r_act_sel   <= ACT_SIGMOID;
         r_pre_sat   <= '0;
         r_y         <= '0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_acc     <= '0;
                  r_idx     <= '0;
                  r_act_sel <= act_sel_e'(act_sel);
               end
            end
            MAC_X: begin
               r_acc <= r_acc + $signed(w_grp_sum);
               r_idx <= w_last_x ? '0 : r_idx + c_IDX_W'(LANES);
            end
            MAC_H: begin
               r_acc <= r_acc + $signed(w_grp_sum);
               r_idx <= w_last_h ? '0 : r_idx + c_IDX_W'(LANES);
            end
            BIAS: r_pre_sat <= w_pre_sat;
            ACT: begin
               if (r_act_sel == ACT_TANH)
                  r_y <= DATA_WIDTH'(tanh_hard(64'(r_pre_sat), FRAC_BITS));
               else
                  r_y <= DATA_WIDTH'(sigmoid_approx(64'(r_pre_sat), FRAC_BITS));
               r_out_valid <= 1'b1;
            end
            OUT: if (out_ready) r_out_valid <= 1'b0;
            default: ;
         endcase
      end
   end

   assign y         = r_y;
   assign out_valid = r_out_valid;

`ifdef GRU_GATE_SAT_FLAG_EN
   logic r_sat_pre;
   logic r_sat_flag;
   logic w_sat_hit;

   assign w_sat_hit = (saturate(64'(w_pre), DATA_WIDTH) != 64'(w_pre));

   // Saturation is captured in BIAS and published alongside y.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sat_pre  <= 1'b0;
         r_sat_flag <= 1'b0;
      end else begin
         if (r_state == BIAS) r_sat_pre <= w_sat_hit;
         if (r_state == ACT)  r_sat_flag <= r_sat_pre;
         else if (r_state == OUT && out_ready) r_sat_flag <= 1'b0;
      end
   end

   assign sat_flag = r_sat_flag;
`else
   // No saturation indicator in this build.
`endif

endmodule

`default_nettype wire

// File: tb/tb_gru_gate_mac_unit.sv
// ============================================================================
// Module  : tb_gru_gate_mac_unit
// Brief   : Directed + random bench for gru_gate_mac_unit (D=4, H=4, LANES=2)
//           against an arithmetic reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gru_gate_mac_unit;

   localparam int c_D   = 4;
   localparam int c_H   = 4;
   localparam int c_DW  = 16;
   localparam int c_FB  = 8;
   localparam int c_LN  = 2;
   localparam int c_LAT = c_D / c_LN + c_H / c_LN + 2;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  in_valid = 1'b0;
   logic                  in_ready;
   logic                  act_sel = 1'b0;
   logic [c_D*c_DW-1:0]   x_t;
   logic [c_H*c_DW-1:0]   h_t_prev;
   logic [c_D*c_DW-1:0]   W_x_row;
   logic [c_H*c_DW-1:0]   W_h_row;
   logic signed [c_DW-1:0] b_x = '0;
   logic signed [c_DW-1:0] b_h = '0;
   logic signed [c_DW-1:0] y;
   logic                  out_valid;
   logic                  out_ready = 1'b0;
`ifdef GRU_GATE_SAT_FLAG_EN
   logic                  sat_flag;
`endif

   logic signed [c_DW-1:0] xv [c_D];
   logic signed [c_DW-1:0] wxv[c_D];
   logic signed [c_DW-1:0] hv [c_H];
   logic signed [c_DW-1:0] whv[c_H];

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   always_comb begin
      x_t = '0; W_x_row = '0; h_t_prev = '0; W_h_row = '0;
      for (int i = 0; i < c_D; i++) begin
         x_t[i*c_DW +: c_DW]     = xv[i];
         W_x_row[i*c_DW +: c_DW] = wxv[i];
      end
      for (int i = 0; i < c_H; i++) begin
         h_t_prev[i*c_DW +: c_DW] = hv[i];
         W_h_row[i*c_DW +: c_DW]  = whv[i];
      end
   end

   gru_gate_mac_unit #(
      .D(c_D), .H(c_H), .DATA_WIDTH(c_DW), .FRAC_BITS(c_FB), .LANES(c_LN)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .act_sel(act_sel), .x_t(x_t), .h_t_prev(h_t_prev),
      .W_x_row(W_x_row), .W_h_row(W_h_row), .b_x(b_x), .b_h(b_h),
      .y(y), .out_valid(out_valid), .out_ready(out_ready)
`ifdef GRU_GATE_SAT_FLAG_EN
      , .sat_flag(sat_flag)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   // Reference: exact dot products, then shift, biases, clamp, activation.
   function automatic void model(input logic act, output logic signed [c_DW-1:0] ey,
                                 output logic es);
      longint acc, pre, ps, one, half, r;
      acc = 0;
      for (int i = 0; i < c_D; i++) acc += longint'(xv[i]) * longint'(wxv[i]);
      for (int i = 0; i < c_H; i++) acc += longint'(hv[i]) * longint'(whv[i]);
      pre = (acc >>> c_FB) + longint'(b_x) + longint'(b_h);
      ps  = pre;
      if (ps > 32767)  ps = 32767;
      if (ps < -32768) ps = -32768;
      es   = (ps != pre);
      one  = 1 << c_FB;
      half = one / 2;
      if (act) begin
         r = (ps > one) ? one : ((ps < -one) ? -one : ps);
      end else begin
         if (ps < -5 * half)     r = 0;
         else if (ps > 5 * half) r = one;
         else                    r = (ps >>> 2) + (ps >>> 3) + half;
      end
      ey = c_DW'(r);
   endfunction

   task automatic fill(input int xs, input int ws, input int hs, input int whs);
      for (int i = 0; i < c_D; i++) begin xv[i] = c_DW'(xs); wxv[i] = c_DW'(ws); end
      for (int i = 0; i < c_H; i++) begin hv[i] = c_DW'(hs); whv[i] = c_DW'(whs); end
   endtask

   task automatic wait_out(output int cyc);
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic run_txn(input logic act, input string tag);
      logic signed [c_DW-1:0] ey;
      logic es;
      int cyc;
      model(act, ey, es);
      act_sel  = act;
      in_valid = 1'b1;
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_out(cyc);
      chk({tag, "_latency"}, 64'(cyc), 64'(c_LAT));
      chk({tag, "_y"}, 64'(y), 64'(ey));
`ifdef GRU_GATE_SAT_FLAG_EN
      chk({tag, "_sat_flag"}, 64'(sat_flag), 64'(es));
`endif
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_valid_clr"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic signed [c_DW-1:0] ey;
      logic es;
      logic signed [c_DW-1:0] y_hold;
      int cyc;

      fill(0, 0, 0, 0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_y", 64'(y), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      rst = 1'b0;

      // Basic sigmoid: pre = 256 -> 224
      fill(256, 64, 0, 0);
      chk("model_basic", 64'(c_DW'(224)), 64'(c_DW'(224)) + 64'(0 * n_assert));
      run_txn(1'b0, "basic_sig");

      // Tanh with positive and negative bias
      b_x = 16'sd256;
      run_txn(1'b1, "tanh_pos");
      b_x = -16'sd1024;
      run_txn(1'b1, "tanh_neg");
      b_x = '0;

      // Saturation both directions
      fill(32767, 32767, 0, 0);
      run_txn(1'b0, "sat_pos");
      fill(-32767, 32767, 0, 0);
      run_txn(1'b0, "sat_neg");

      // Lane ordering
      fill(0, 0, 0, 0);
      xv[0] = 16'sd256; xv[1] = 16'sd512; xv[2] = 16'sd768; xv[3] = 16'sd1024;
      wxv[0] = 16'sd256; wxv[3] = -16'sd256;
      run_txn(1'b0, "lane_order");
      run_txn(1'b1, "lane_order_tanh");

      // Backpressure: hold output, ignore new requests while busy
      fill(300, 40, -100, 20);
      b_h = 16'sd17;
      model(1'b1, ey, es);
      act_sel  = 1'b1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_out(cyc);
      chk("bp_latency", 64'(cyc), 64'(c_LAT));
      y_hold = y;
      chk("bp_y", 64'(y), 64'(ey));
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("bp_y_stable", 64'(y), 64'(y_hold));
         chk("bp_valid_held", 64'(out_valid), 64'd1);
         chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_release_valid", 64'(out_valid), 64'd0);
      chk("bp_release_ready", 64'(in_ready), 64'd1);
      b_h = '0;
      fill(-50, 90, 70, -33);
      run_txn(1'b0, "bp_back_to_back");

      // Reset in MAC_H aborts; follow-up transaction has no residue
      fill(32767, 32767, 32767, 32767);
      act_sel  = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_y", 64'(y), 64'd0);
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      chk("abort_in_ready", 64'(in_ready), 64'd1);
      fill(256, 64, 0, 0);
      run_txn(1'b0, "after_abort");

      // Random operands, mixed ranges and activations
      for (int t = 0; t < 12; t++) begin
         for (int i = 0; i < c_D; i++) begin
            xv[i]  = (t % 2 == 0) ? c_DW'($urandom_range(0, 2047)) - 16'sd1024 : c_DW'($urandom);
            wxv[i] = (t % 2 == 0) ? c_DW'($urandom_range(0, 511)) - 16'sd256 : c_DW'($urandom);
         end
         for (int i = 0; i < c_H; i++) begin
            hv[i]  = c_DW'($urandom_range(0, 2047)) - 16'sd1024;
            whv[i] = c_DW'($urandom_range(0, 511)) - 16'sd256;
         end
         b_x = c_DW'($urandom_range(0, 1023)) - 16'sd512;
         b_h = c_DW'($urandom_range(0, 1023)) - 16'sd512;
         run_txn(1'($urandom_range(0, 1)), "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/gru_gate_mac_unit.md
Name: gru_gate_mac_unit

Overview:
- Parametrised successor of the single-row GRU gate element.
- Computes one gate neuron per transaction: y = act(W_x·x + W_h·h_prev + b_x + b_h).
- Adds LANES-wide parallel MAC, an accumulator width that cannot overflow, saturation to DATA_WIDTH, runtime sigmoid/tanh select, and valid/ready handshakes on both sides.
- Instantiated per row by the gate array controller for r, z and candidate-n gates.

Parameters:
- D, 128, input vector length.
- H, 256, hidden vector length.
- DATA_WIDTH, 16, signed fixed-point operand width.
- FRAC_BITS, 8, fractional bits (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS).
- LANES, 4, multiply-accumulates per cycle. D%LANES==0 and H%LANES==0 are required; an elaboration-time assertion enforces this.
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(D+H), accumulator width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request to start a transaction
- in_ready  out  1  high only in IDLE
- act_sel  in  1  0=sigmoid, 1=tanh; sampled at accept
- x_t  in  D x DATA_WIDTH  input vector
- h_t_prev  in  H x DATA_WIDTH  previous hidden state
- W_x_row  in  D x DATA_WIDTH  input weight row
- W_h_row  in  H x DATA_WIDTH  hidden weight row
- b_x, b_h  in  DATA_WIDTH each  biases
- y  out  DATA_WIDTH  activated result
- out_valid  out  1  y is valid
- out_ready  in  1  consumer accepts y

Behaviour:
- Reset: synchronous, active-high. Clears y=0, out_valid=0, accumulator=0, index=0; state=IDLE. A reset mid-transaction aborts it with no output.
- Accept: in_valid && in_ready at a rising edge. Latches act_sel, clears the accumulator, sets index=0.
- Operand stability: arrays and biases are not registered. They must stay stable from accept until out_valid.
- States:
  - IDLE -> MAC_X on accept.
  - MAC_X: D/LANES cycles. Each cycle adds LANES products at indices idx..idx+LANES-1 and advances idx by LANES. Goes to MAC_H after the last group; idx resets.
  - MAC_H: H/LANES cycles, same as MAC_X but on W_h_row/h_t_prev. Goes to BIAS.
  - BIAS: pre = (acc >>> FRAC_BITS) + sext(b_x) + sext(b_h), computed at ACC_WIDTH. The result saturates to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - ACT: y <= act(pre_sat); out_valid <= 1.
  - OUT: holds y and out_valid until out_ready. On out_ready, clears out_valid and goes to IDLE. The next accept is possible one cycle later.
- Products: full 2*DATA_WIDTH signed, sign-extended into ACC_WIDTH. No intermediate truncation.
- Latency: out_valid rises D/LANES + H/LANES + 2 cycles after the accept edge.
- Sigmoid, with one = 1<<FRAC_BITS and half = one>>1:
  - 0 if x < -5*half.
  - one if x > 5*half.
  - Otherwise (x>>>2)+(x>>>3)+half.
- Tanh (hard tanh): clamp x to [-one, one].
- Simultaneous events: in_valid while busy is ignored; in_ready is low. out_ready while out_valid is low is ignored.

Optional Feature:
- Macro: GRU_GATE_SAT_FLAG_EN.
- Defined: adds output sat_flag (1 bit), reset 0. It is registered with y and high while out_valid if BIAS saturated pre. It clears with out_valid.
- Undefined: the port and its logic are absent. Functional behaviour is otherwise identical.

Decomposition:
- Package gru_pkg holds:
  - the state_t enum (IDLE, MAC_X, MAC_H, BIAS, ACT, OUT);
  - the act_sel_e enum (ACT_SIGMOID, ACT_TANH);
  - the sigmoid_approx, tanh_hard and saturate functions, parameterised by width and fraction bits.
- One natural sub-module, gru_mac_lanes: a combinational LANES-wide product-sum tree that returns the ACC_WIDTH group sum. The FSM and accumulator stay in the top module.

Test Plan (D=4, H=4, LANES=2, DATA_WIDTH=16, FRAC_BITS=8):
- Basic sigmoid: x=256, W_x=64, h=0, biases 0, act_sel=0 -> pre=256, y=224. out_valid exactly 6 cycles after accept.
- Tanh with bias: as above plus b_x=256, act_sel=1 -> pre=512, y=256. With b_x=-1024 -> pre=-768, y=-256.
- Saturation: all x, W_x = 32767 -> pre clamps to 32767, sigmoid y=256; sat_flag=1 when GRU_GATE_SAT_FLAG_EN is defined. The negated case -> y=0.
- Backpressure: out_ready held low 5 cycles -> y and out_valid stable, in_ready=0, a new in_valid is ignored. out_ready=1 -> IDLE next cycle, back-to-back accept succeeds.
- Reset mid-MAC: rst high during MAC_H -> next cycle y=0, out_valid=0, in_ready=1. A following transaction gives the correct result with no residue from the aborted one.
- Lane ordering: x=[1,2,3,4]<<8, W_x=[256,0,0,-256], h=0 -> pre=-768, sigmoid y=0.
